// File: rtl/ndp_stream_ctrl.sv
// Streaming front-end for a grid of systolic arrays: diagonal skew of A/B beats, tile sequencing
// (feed, flush, drain, hold), result handshake toward the downstream writer and tile counting.
module ndp_stream_ctrl #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned ARR_WIDTH   = 4,
   parameter int unsigned ARR_HEIGHT  = 4,
   parameter int unsigned SYS_WIDTH   = 64,
   parameter int unsigned SYS_HEIGHT  = 1,
   parameter int unsigned DRAIN_EXTRA = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 abort,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0] s_a,
   input  logic [ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]   s_b,
   input  logic                                 s_last,
   output logic [ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0] arr_a,
   output logic [ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]   arr_b,
   output logic                                 arr_done,
   output logic                                 arr_clear,
   output logic                                 res_valid,
   input  logic                                 res_ready,
   output logic                                 busy,
   output logic [CNT_W-1:0]                     tile_count
);

   localparam int unsigned A_LANES   = ARR_HEIGHT * SYS_HEIGHT;
   localparam int unsigned B_LANES   = ARR_WIDTH * SYS_WIDTH;
   localparam int unsigned A_BITS    = A_LANES * WIDTH;
   localparam int unsigned B_BITS    = B_LANES * WIDTH;
   localparam int unsigned FLUSH_CYC = ARR_WIDTH + ARR_HEIGHT;
   localparam int unsigned PH_MAX    = (FLUSH_CYC > DRAIN_EXTRA) ? FLUSH_CYC : DRAIN_EXTRA;
   localparam int unsigned PH_W      = $clog2(PH_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FEED  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_DRAIN = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
   logic              arr_done_q, arr_done_d;
   logic              res_valid_q, res_valid_d;
   logic              arr_clear_q, arr_clear_d;
   logic [CNT_W-1:0]  tile_count_q, tile_count_d;

   logic              beat;
   logic [A_BITS-1:0] a_in;
   logic [B_BITS-1:0] b_in;

   // Beats are only taken while feeding; abort blocks acceptance in the same cycle.
   assign s_ready = ((state_q == ST_IDLE) || (state_q == ST_FEED)) && !abort;
   assign beat    = s_valid && s_ready;
   assign a_in    = beat ? s_a : '0;
   assign b_in    = beat ? s_b : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         ph_cnt_q     <= '0;
         arr_done_q   <= 1'b0;
         res_valid_q  <= 1'b0;
         arr_clear_q  <= 1'b0;
         tile_count_q <= '0;
      end else begin
         state_q      <= state_d;
         ph_cnt_q     <= ph_cnt_d;
         arr_done_q   <= arr_done_d;
         res_valid_q  <= res_valid_d;
         arr_clear_q  <= arr_clear_d;
         tile_count_q <= tile_count_d;
      end
   end

   // Next-state and registered-output logic; abort overrides every state transition.
   always_comb begin
      state_d      = state_q;
      ph_cnt_d     = ph_cnt_q;
      arr_done_d   = arr_done_q;
      res_valid_d  = res_valid_q;
      arr_clear_d  = 1'b0;
      tile_count_d = tile_count_q;

      if (abort) begin
         state_d     = ST_IDLE;
         ph_cnt_d    = '0;
         arr_done_d  = 1'b0;
         res_valid_d = 1'b0;
         arr_clear_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_FEED: begin
               if (beat) begin
                  state_d  = s_last ? ST_FLUSH : ST_FEED;
                  ph_cnt_d = '0;
               end
            end
            ST_FLUSH: begin
               if (ph_cnt_q == PH_W'(FLUSH_CYC - 1)) begin
                  state_d    = ST_DRAIN;
                  ph_cnt_d   = '0;
                  arr_done_d = 1'b1;
               end else begin
                  ph_cnt_d = ph_cnt_q + PH_W'(1);
               end
            end
            ST_DRAIN: begin
               if (ph_cnt_q == PH_W'(DRAIN_EXTRA - 1)) begin
                  state_d     = ST_HOLD;
                  ph_cnt_d    = '0;
                  res_valid_d = 1'b1;
               end else begin
                  ph_cnt_d = ph_cnt_q + PH_W'(1);
               end
            end
            ST_HOLD: begin
               if (res_ready) begin
                  state_d      = ST_IDLE;
                  res_valid_d  = 1'b0;
                  arr_done_d   = 1'b0;
                  arr_clear_d  = 1'b1;
                  tile_count_d = tile_count_q + CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A skew: lane k inside its array sits behind k+1 register stages.
   for (genvar n = 0; n < A_LANES; n++) begin : g_skew_a
      localparam int unsigned DEPTH = (n % ARR_HEIGHT) + 1;
      localparam int unsigned SRW   = DEPTH * WIDTH;
      logic [SRW-1:0] sr_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sr_q <= '0;
         end else if (abort) begin
            sr_q <= '0;
         end else begin
            sr_q <= SRW'({sr_q, a_in[n*WIDTH +: WIDTH]});
         end
      end

      assign arr_a[n*WIDTH +: WIDTH] = sr_q[SRW-1 -: WIDTH];
   end

   // B skew: lane l inside its array sits behind l+1 register stages.
   for (genvar n = 0; n < B_LANES; n++) begin : g_skew_b
      localparam int unsigned DEPTH = (n % ARR_WIDTH) + 1;
      localparam int unsigned SRW   = DEPTH * WIDTH;
      logic [SRW-1:0] sr_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sr_q <= '0;
         end else if (abort) begin
            sr_q <= '0;
         end else begin
            sr_q <= SRW'({sr_q, b_in[n*WIDTH +: WIDTH]});
         end
      end

      assign arr_b[n*WIDTH +: WIDTH] = sr_q[SRW-1 -: WIDTH];
   end

   assign arr_done   = arr_done_q;
   assign res_valid  = res_valid_q;
   assign arr_clear  = arr_clear_q;
   assign tile_count = tile_count_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
